// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file write-back front end.
package regwb_pkg;

    localparam int SIZE       = 32;
    localparam int AMOUNT_REG = 4;

    // R15 is the PC and is never written through this port.
    localparam logic [AMOUNT_REG-1:0] PC_REG = 4'd15;

    typedef struct packed {
        logic [AMOUNT_REG-1:0] rd;
        logic [SIZE-1:0]       wd;
    } wb_req_t;

endpackage

// File: rtl/reg_writeback_chk.sv
// Protocol checker: the pipeline must never issue an ALU write to a register with a load in flight.
module reg_writeback_chk #(
    parameter int AMOUNT_REG = 4
) (
    input logic                  CLK,
    input logic                  RST_N,
    input logic                  ALU_VALID,
    input logic [AMOUNT_REG-1:0] ALU_RD,
    input logic [15:0]           PENDING
);

    alu_vs_pending_a: assert property (@(posedge CLK) disable iff (!RST_N)
        ALU_VALID |-> !PENDING[ALU_RD]);

endmodule

// File: rtl/wb_fifo.sv
// In-order holding queue for load results that lost write-port arbitration.
module wb_fifo
    import regwb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          push,
    input  wb_req_t       push_data,
    input  logic          pop,
    output wb_req_t       head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_req_t       mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;

    // Guard against overrun/underrun so the pointers can never corrupt.
    assign push_s = push && (count_r != FULL_CNT);
    assign pop_s  = pop && (count_r != '0);

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == '0);
    assign count = count_r;

    // Storage, wrap-around pointers and occupancy count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU and load results onto the register file's single write port and
// tracks outstanding loads per destination register for the hazard unit.
module reg_writeback #(
    parameter int SIZE       = regwb_pkg::SIZE,
    parameter int AMOUNT_REG = regwb_pkg::AMOUNT_REG,
    parameter int DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ALU_VALID,
    input  logic [AMOUNT_REG-1:0] ALU_RD,
    input  logic [SIZE-1:0]       ALU_WD,
    input  logic                  LD_ISSUE_VALID,
    input  logic [AMOUNT_REG-1:0] LD_ISSUE_RD,
    input  logic                  LD_VALID,
    input  logic [AMOUNT_REG-1:0] LD_RD,
    input  logic [SIZE-1:0]       LD_WD,
    output logic                  LD_READY,
    output logic                  WE3,
    output logic [AMOUNT_REG-1:0] RA3,
    output logic [SIZE-1:0]       WD3,
    output logic [15:0]           PENDING,
    output logic                  LD_OVF
);

    import regwb_pkg::wb_req_t;
    import regwb_pkg::PC_REG;

    localparam int           CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wb_req_t               alu_req_s;
    wb_req_t               ld_req_s;
    wb_req_t               head_s;
    wb_req_t               issue_req_s;
    logic                  issue_s;
    logic                  issue_load_s;
    logic                  bypass_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  we_next_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CW-1:0]         count_s;
    logic [15:0]           pend_set_s;
    logic [15:0]           pend_clr_s;

    logic                  we3_r;
    logic [AMOUNT_REG-1:0] ra3_r;
    logic [SIZE-1:0]       wd3_r;
    logic [15:0]           pending_r;
    logic                  ld_ovf_r;

    assign alu_req_s = {ALU_RD, ALU_WD};
    assign ld_req_s  = {LD_RD, LD_WD};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (push_s),
        .push_data (ld_req_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (count_s)
    );

    // Fixed-priority arbiter: ALU, then queued loads, then a bypassing load.
    always_comb begin
        issue_s      = 1'b0;
        issue_load_s = 1'b0;
        issue_req_s  = '0;
        bypass_s     = 1'b0;
        pop_s        = 1'b0;
        if (ALU_VALID) begin
            issue_s     = 1'b1;
            issue_req_s = alu_req_s;
        end else if (!fifo_empty_s) begin
            issue_s      = 1'b1;
            issue_load_s = 1'b1;
            issue_req_s  = head_s;
            pop_s        = 1'b1;
        end else if (LD_VALID) begin
            issue_s      = 1'b1;
            issue_load_s = 1'b1;
            issue_req_s  = ld_req_s;
            bypass_s     = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // A load that did not bypass is queued; readiness ignores a same-cycle pop.
    assign push_s    = LD_VALID && !bypass_s && !fifo_full_s;
    assign drop_s    = LD_VALID && !bypass_s && fifo_full_s;
    assign we_next_s = issue_s && (issue_req_s.rd != PC_REG);
    assign LD_READY  = (count_s < DEPTH_C);

    // Scoreboard set/clear vectors; the PC is never tracked.
    always_comb begin
        pend_set_s = 16'h0000;
        pend_clr_s = 16'h0000;
        if (LD_ISSUE_VALID && (LD_ISSUE_RD != PC_REG)) begin
            pend_set_s[LD_ISSUE_RD] = 1'b1;
        end else begin
            pend_set_s = 16'h0000;
        end
        if (issue_load_s && (issue_req_s.rd != PC_REG)) begin
            pend_clr_s[issue_req_s.rd] = 1'b1;
        end else begin
            pend_clr_s = 16'h0000;
        end
    end

    // Registered write port, scoreboard (set beats clear) and sticky overflow.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we3_r     <= 1'b0;
            ra3_r     <= '0;
            wd3_r     <= '0;
            pending_r <= 16'h0000;
            ld_ovf_r  <= 1'b0;
        end else begin
            we3_r <= we_next_s;
            if (we_next_s) begin
                ra3_r <= issue_req_s.rd;
                wd3_r <= issue_req_s.wd;
            end
            pending_r <= (pending_r & ~pend_clr_s) | pend_set_s;
            if (drop_s) begin
                ld_ovf_r <= 1'b1;
            end
        end
    end

    assign WE3     = we3_r;
    assign RA3     = ra3_r;
    assign WD3     = wd3_r;
    assign PENDING = pending_r;
    assign LD_OVF  = ld_ovf_r;

    reg_writeback_chk #(.AMOUNT_REG(AMOUNT_REG)) u_chk (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ALU_VALID (ALU_VALID),
        .ALU_RD    (ALU_RD),
        .PENDING   (pending_r)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: stimulus pushes expected writes, a forked monitor pops and compares.
module tb_reg_writeback;
    import regwb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ALU_VALID, LD_ISSUE_VALID, LD_VALID;
    logic [3:0]  ALU_RD, LD_ISSUE_RD, LD_RD;
    logic [31:0] ALU_WD, LD_WD;
    logic        LD_READY, WE3, LD_OVF;
    logic [3:0]  RA3;
    logic [31:0] WD3;
    logic [15:0] PENDING;

    wb_req_t exp_q[$];
    wb_req_t mon_e;
    int      checks = 0;
    int      errors = 0;

    always #5 CLK = ~CLK;

    reg_writeback #(.SIZE(32), .AMOUNT_REG(4), .DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_WD(ALU_WD),
        .LD_ISSUE_VALID(LD_ISSUE_VALID), .LD_ISSUE_RD(LD_ISSUE_RD),
        .LD_VALID(LD_VALID), .LD_RD(LD_RD), .LD_WD(LD_WD),
        .LD_READY(LD_READY), .WE3(WE3), .RA3(RA3), .WD3(WD3),
        .PENDING(PENDING), .LD_OVF(LD_OVF)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic idle();
        ALU_VALID = 1'b0; ALU_RD = 4'd0; ALU_WD = 32'd0;
        LD_ISSUE_VALID = 1'b0; LD_ISSUE_RD = 4'd0;
        LD_VALID = 1'b0; LD_RD = 4'd0; LD_WD = 32'd0;
    endtask

    task automatic push_exp(input logic [3:0] rd, input logic [31:0] wd);
        wb_req_t r;
        r.rd = rd;
        r.wd = wd;
        exp_q.push_back(r);
    endtask

    initial begin
        idle();
        RST_N = 1'b0;

        fork
            forever begin
                @(negedge CLK);
                if (WE3 === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got RA3=%0d WD3=%0h, expected no write", RA3, WD3);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wb_ra3", 32'(RA3), 32'(mon_e.rd));
                        check("wb_wd3", WD3, mon_e.wd);
                    end
                end
            end
        join_none

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            ALU_VALID = 1'($urandom); ALU_RD = 4'($urandom); ALU_WD = $urandom;
            LD_ISSUE_VALID = 1'($urandom); LD_ISSUE_RD = 4'($urandom);
            LD_VALID = 1'($urandom); LD_RD = 4'($urandom); LD_WD = $urandom;
        end
        @(negedge CLK);
        check("rst_we3", 32'(WE3), 32'd0);
        check("rst_ra3", 32'(RA3), 32'd0);
        check("rst_wd3", WD3, 32'd0);
        check("rst_pending", 32'(PENDING), 32'd0);
        check("rst_ovf", 32'(LD_OVF), 32'd0);
        check("rst_ready", 32'(LD_READY), 32'd1);
        idle();
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Single ALU write
        ALU_VALID = 1'b1; ALU_RD = 4'd3; ALU_WD = 32'hDEADBEEF;
        push_exp(4'd3, 32'hDEADBEEF);
        @(negedge CLK);
        idle();
        check("alu_we_next_cycle", 32'(WE3), 32'd1);
        @(negedge CLK);
        check("alu_we_one_cycle", 32'(WE3), 32'd0);

        // Collision: ALU R1 and load R2 together
        LD_ISSUE_VALID = 1'b1; LD_ISSUE_RD = 4'd2;
        @(negedge CLK);
        idle();
        check("coll_pending_set", 32'(PENDING[2]), 32'd1);
        ALU_VALID = 1'b1; ALU_RD = 4'd1; ALU_WD = 32'h11;
        LD_VALID = 1'b1; LD_RD = 4'd2; LD_WD = 32'h22;
        push_exp(4'd1, 32'h11);
        push_exp(4'd2, 32'h22);
        @(negedge CLK);
        idle();
        check("coll_first_ra3", 32'(RA3), 32'd1);
        check("coll_pending_held", 32'(PENDING[2]), 32'd1);
        @(negedge CLK);
        check("coll_second_we", 32'(WE3), 32'd1);
        check("coll_second_ra3", 32'(RA3), 32'd2);
        check("coll_pending_clr", 32'(PENDING[2]), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            LD_ISSUE_VALID = 1'b1; LD_ISSUE_RD = 4'(4 + i);
        end
        @(negedge CLK);
        idle();
        check("fill_pending", 32'(PENDING), 32'h01F0);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) check("fill_ready_at3", 32'(LD_READY), 32'd1);
            if (i == 4) check("fill_ready_low", 32'(LD_READY), 32'd0);
            ALU_VALID = 1'b1; ALU_RD = 4'd0; ALU_WD = 32'h100 + 32'(i);
            LD_VALID = 1'b1; LD_RD = 4'(4 + i); LD_WD = 32'h40 + 32'(i);
            push_exp(4'd0, 32'h100 + 32'(i));
            @(negedge CLK);
        end
        idle();
        for (int i = 0; i < 4; i++) push_exp(4'(4 + i), 32'h40 + 32'(i));
        check("fill_ovf", 32'(LD_OVF), 32'd1);
        repeat (5) @(negedge CLK);
        check("drain_pending", 32'(PENDING), 32'h0100);
        check("drain_ready", 32'(LD_READY), 32'd1);
        check("drain_ovf_sticky", 32'(LD_OVF), 32'd1);

        // PC filter
        ALU_VALID = 1'b1; ALU_RD = 4'd15; ALU_WD = 32'h0BAD;
        LD_ISSUE_VALID = 1'b1; LD_ISSUE_RD = 4'd15;
        @(negedge CLK);
        idle();
        LD_VALID = 1'b1; LD_RD = 4'd15; LD_WD = 32'h0BAD2;
        @(negedge CLK);
        idle();
        check("pc_pending15", 32'(PENDING[15]), 32'd0);
        @(negedge CLK);
        check("pc_no_we", 32'(WE3), 32'd0);
        repeat (2) @(negedge CLK);

        // Scoreboard race: set wins over clear on R9
        LD_ISSUE_VALID = 1'b1; LD_ISSUE_RD = 4'd9;
        @(negedge CLK);
        idle();
        check("race_pending_pre", 32'(PENDING[9]), 32'd1);
        LD_VALID = 1'b1; LD_RD = 4'd9; LD_WD = 32'h99;
        LD_ISSUE_VALID = 1'b1; LD_ISSUE_RD = 4'd9;
        push_exp(4'd9, 32'h99);
        @(negedge CLK);
        idle();
        check("race_set_wins", 32'(PENDING[9]), 32'd1);

        // Mid-queue reset
        for (int i = 0; i < 3; i++) begin
            ALU_VALID = 1'b1; ALU_RD = 4'd0; ALU_WD = 32'h200 + 32'(i);
            LD_VALID = 1'b1; LD_RD = 4'(10 + i); LD_WD = 32'hA0 + 32'(i);
            push_exp(4'd0, 32'h200 + 32'(i));
            @(negedge CLK);
        end
        check("mq_ready_before", 32'(LD_READY), 32'd1);
        #1;
        RST_N = 1'b0;
        idle();
        @(negedge CLK);
        check("mq_rst_ready", 32'(LD_READY), 32'd1);
        check("mq_rst_pending", 32'(PENDING), 32'd0);
        check("mq_rst_ovf", 32'(LD_OVF), 32'd0);
        check("mq_rst_we3", 32'(WE3), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (8) @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
